// File: rtl/watch_mode_ctrl_pkg.sv
// Shared types and constants for the watch mode controller: state encoding,
// digit-enable masks and the BCD digit width.
package watch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_SEC = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  // Digit enable masks, bit3 = min10 ... bit0 = sec1
  localparam logic [3:0] DIGITS_ALL       = 4'b1111;
  localparam logic [3:0] DIGITS_SEC_BLANK = 4'b1100;
  localparam logic [3:0] DIGITS_MIN_BLANK = 4'b0011;

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// Strobe/button inputs and display outputs of the watch mode controller.
// The controller's current state is exposed on 'state' for observation.
// All inputs are 1-cycle pulses sampled on the rising clock edge; outputs
// are registered-state derived and change only after a clock edge.
interface watch_mode_ctrl_if;
  logic        tick_sec;
  logic        tick_msec;
  logic        btn_mode_pe;
  logic        btn_up_pe;
  logic        btn_down_pe;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        set_mode;
  logic        hour_carry;
  logic [1:0]  state;

  modport master (
    output tick_sec, tick_msec, btn_mode_pe, btn_up_pe, btn_down_pe,
    input  value, digit_en, set_mode, hour_carry, state
  );

  modport slave (
    input  tick_sec, tick_msec, btn_mode_pe, btn_up_pe, btn_down_pe,
    output value, digit_en, set_mode, hour_carry, state
  );
endinterface

// File: rtl/watch_mode_ctrl_bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX) with up/down steps. Increment past
// MAX wraps to 00 and, when carry_en is set, raises 'carry' in that cycle.
// Decrement below 00 wraps to MAX and never borrows.
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               carry_en,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX % 10);

  logic at_max;
  logic at_zero;

  assign at_max  = (tens == MAX_T) && (ones == MAX_O);
  assign at_zero = (tens == '0) && (ones == '0);

  // Wrap-out pulse for chaining into the next field; simultaneous inc/dec cancels
  assign carry = inc & ~dec & carry_en & at_max;

  // BCD step: units roll 9->0 into tens on increment, 0->9 out of tens on decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc && !dec) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == DIGIT_W'(9)) begin
        tens <= tens + DIGIT_W'(1);
        ones <= '0;
      end else begin
        ones <= ones + DIGIT_W'(1);
      end
    end else if (dec && !inc) begin
      if (at_zero) begin
        tens <= MAX_T;
        ones <= MAX_O;
      end else if (ones == '0) begin
        tens <= tens - DIGIT_W'(1);
        ones <= DIGIT_W'(9);
      end else begin
        ones <= ones - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode and time-set controller for a 4-digit min:sec watch.
// RUN counts seconds from tick_sec; SET_SEC / SET_MIN edit one field with
// up/down buttons while the edited digit pair blinks.
// Optional macro WATCH_AUTO_EXIT_EN: returns to RUN after AUTO_EXIT_SEC idle
// seconds in a set mode.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int MIN_MAX       = 59,
  parameter int BLINK_MS      = 500,
  parameter int AUTO_EXIT_SEC = 10
) (
  input  logic                clk,
  input  logic                reset_p,
  watch_mode_ctrl_if.slave    bus
);

  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  state_t               state;
  state_t               next_state;
  logic                 run_mode;
  logic                 state_chg;
  logic                 auto_exit;
  logic                 edit_up;
  logic                 edit_down;
  logic                 sec_inc, sec_dec, min_inc, min_dec;
  logic                 sec_carry, min_carry;
  logic [DIGIT_W-1:0]   sec_t, sec_o, min_t, min_o;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic                 hour_carry_q;

  assign run_mode  = (state == RUN);
  assign state_chg = (next_state != state);

  // An edit is accepted only alone: mode press or auto-exit discards it,
  // and up+down together cancel out.
  assign edit_up   = bus.btn_up_pe & ~bus.btn_down_pe & ~bus.btn_mode_pe & ~auto_exit;
  assign edit_down = bus.btn_down_pe & ~bus.btn_up_pe & ~bus.btn_mode_pe & ~auto_exit;

  assign sec_inc = run_mode ? bus.tick_sec : ((state == SET_SEC) & edit_up);
  assign sec_dec = (state == SET_SEC) & edit_down;
  assign min_inc = run_mode ? sec_carry : ((state == SET_MIN) & edit_up);
  assign min_dec = (state == SET_MIN) & edit_down;

  bcd_mod_counter #(.MAX(59)) u_sec (
    .clk      (clk),
    .rst      (reset_p),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .carry_en (run_mode),
    .tens     (sec_t),
    .ones     (sec_o),
    .carry    (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (reset_p),
    .inc      (min_inc),
    .dec      (min_dec),
    .carry_en (run_mode),
    .tens     (min_t),
    .ones     (min_o),
    .carry    (min_carry)
  );

`ifdef WATCH_AUTO_EXIT_EN
  localparam int IDLE_W = $clog2(AUTO_EXIT_SEC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_EXIT_SEC);

  logic [IDLE_W-1:0] idle_cnt;
  logic              any_btn;

  assign any_btn   = bus.btn_mode_pe | bus.btn_up_pe | bus.btn_down_pe;
  assign auto_exit = ~run_mode & (idle_cnt == IDLE_LAST);

  // Idle seconds in a set mode; any button or state change restarts the count
  always_ff @(posedge clk) begin
    if (reset_p || state_chg || any_btn || run_mode) begin
      idle_cnt <= '0;
    end else if (bus.tick_sec && (idle_cnt != IDLE_LAST)) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  // Feature compiled out: the comparison folds to a constant zero
  assign auto_exit = (AUTO_EXIT_SEC < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state: mode button cycles RUN->SET_SEC->SET_MIN->RUN; auto-exit wins
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (bus.btn_mode_pe) next_state = SET_SEC;
      SET_SEC: if (bus.btn_mode_pe) next_state = SET_MIN;
      SET_MIN: if (bus.btn_mode_pe) next_state = RUN;
      default: next_state = RUN;
    endcase
    if (auto_exit) begin
      next_state = RUN;
    end
  end

  // Blink timer: restart on state change or accepted edit so the field shows at once
  always_ff @(posedge clk) begin
    if (reset_p || state_chg || edit_up || edit_down || run_mode) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.tick_msec) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Hour carry registered so it lines up with the displayed 00:00
  always_ff @(posedge clk) begin
    if (reset_p) begin
      hour_carry_q <= 1'b0;
    end else begin
      hour_carry_q <= min_carry;
    end
  end

  // Outputs derived from registered state only
  always_comb begin
    bus.value      = {min_t, min_o, sec_t, sec_o};
    bus.set_mode   = ~run_mode;
    bus.hour_carry = hour_carry_q;
    bus.state      = state;
    bus.digit_en   = DIGITS_ALL;
    if (blink_phase) begin
      if (state == SET_SEC)      bus.digit_en = DIGITS_SEC_BLANK;
      else if (state == SET_MIN) bus.digit_en = DIGITS_MIN_BLANK;
    end
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus random stimulus, all
// checked every cycle against a time-in-seconds reference model.
module tb_watch_mode_ctrl;

  localparam int MIN_MAX       = 59;
  localparam int BLINK_MS      = 500;
  localparam int AUTO_EXIT_SEC = 10;
`ifdef WATCH_AUTO_EXIT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic clk;
  logic reset_p;
  watch_mode_ctrl_if bus();

  watch_mode_ctrl #(
    .MIN_MAX       (MIN_MAX),
    .BLINK_MS      (BLINK_MS),
    .AUTO_EXIT_SEC (AUTO_EXIT_SEC)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Time held as plain integers; blink phase derived from msec since last clear.
  int m_sec, m_min, m_mode, m_ms, m_idle;
  bit m_hc;
  logic [23:0] exp_q[$];

  function automatic logic [3:0] exp_digits(int mode, int ms);
    bit ph;
    ph = ((ms / BLINK_MS) % 2) == 1;
    if (mode == 1 && ph) return 4'b1100;
    if (mode == 2 && ph) return 4'b0011;
    return 4'b1111;
  endfunction

  always @(posedge clk) begin
    int total, nmode;
    bit ax, eu, ed, chg, ts, tm, mo, up, dn;
    ts = bus.tick_sec; tm = bus.tick_msec; mo = bus.btn_mode_pe;
    up = bus.btn_up_pe; dn = bus.btn_down_pe;
    if (reset_p) begin
      m_sec = 0; m_min = 0; m_mode = 0; m_ms = 0; m_idle = 0; m_hc = 0;
    end else begin
      ax = AUTO_EN && (m_mode != 0) && (m_idle >= AUTO_EXIT_SEC);
      eu = up && !dn && !mo && !ax;
      ed = dn && !up && !mo && !ax;
      nmode = ax ? 0 : (mo ? (m_mode + 1) % 3 : m_mode);
      m_hc = 0;
      if (m_mode == 0) begin
        if (ts) begin
          total = m_min * 60 + m_sec + 1;
          if (total == (MIN_MAX + 1) * 60) begin
            total = 0;
            m_hc  = 1;
          end
          m_sec = total % 60;
          m_min = total / 60;
        end
      end else if (m_mode == 1) begin
        if (eu) m_sec = (m_sec + 1) % 60;
        else if (ed) m_sec = (m_sec + 59) % 60;
      end else begin
        if (eu) m_min = (m_min + 1) % (MIN_MAX + 1);
        else if (ed) m_min = (m_min + MIN_MAX) % (MIN_MAX + 1);
      end
      chg = (nmode != m_mode);
      if (chg || eu || ed) m_ms = 0;
      else if (m_mode != 0 && tm) m_ms++;
      if (chg || mo || up || dn) m_idle = 0;
      else if (m_mode != 0 && ts && m_idle < AUTO_EXIT_SEC) m_idle++;
      m_mode = nmode;
    end
    exp_q.push_back({2'(m_mode),
                     4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                     exp_digits(m_mode, m_ms), (m_mode != 0), m_hc});
  end

  // ---------------- scoreboard compare (every cycle, opposite edge) ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",      32'(bus.state),      32'(e[23:22]));
      check("value",      32'(bus.value),      32'(e[21:6]));
      check("digit_en",   32'(bus.digit_en),   32'(e[5:2]));
      check("set_mode",   32'(bus.set_mode),   32'(e[1]));
      check("hour_carry", 32'(bus.hour_carry), 32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle with the given pulses; returns 1 time unit after the edge.
  task automatic cyc(input bit ts, input bit tm, input bit mo, input bit up, input bit dn);
    bus.tick_sec    = ts;
    bus.tick_msec   = tm;
    bus.btn_mode_pe = mo;
    bus.btn_up_pe   = up;
    bus.btn_down_pe = dn;
    @(posedge clk);
    #1;
    bus.tick_sec = 0; bus.tick_msec = 0; bus.btn_mode_pe = 0;
    bus.btn_up_pe = 0; bus.btn_down_pe = 0;
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset_p = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_p = 1'b1;
    bus.tick_sec = 0; bus.tick_msec = 0; bus.btn_mode_pe = 0;
    bus.btn_up_pe = 0; bus.btn_down_pe = 0;

    // Reset state
    do_reset();
    check("rst_value",    32'(bus.value), 32'h0000);
    check("rst_digit_en", 32'(bus.digit_en), 32'hF);
    check("rst_set_mode", 32'(bus.set_mode), 0);
    check("rst_hc",       32'(bus.hour_carry), 0);

    // 60 seconds in RUN -> 01:00
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0, 0);
    check("run60_value", 32'(bus.value), 32'h0100);
    check("model_min",   32'(m_min), 1);
    check("model_sec",   32'(m_sec), 0);

    // SET_SEC down at 00:00 -> 00:59, then reach 59:59 and roll over
    do_reset();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("setsec_down_value", 32'(bus.value), 32'h0059);
    check("setsec_set_mode",   32'(bus.set_mode), 1);
    check("setsec_hc",         32'(bus.hour_carry), 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("setmin_down_value", 32'(bus.value), 32'h5959);
    cyc(0, 0, 1, 0, 0);
    check("back_run_state", 32'(bus.state), 0);
    cyc(1, 0, 0, 0, 0);
    check("wrap_value", 32'(bus.value), 32'h0000);
    check("wrap_hc",    32'(bus.hour_carry), 1);
    check("model_hc",   32'(m_hc), 1);
    cyc(0, 0, 0, 0, 0);
    check("hc_one_cycle", 32'(bus.hour_carry), 0);

    // SET_MIN at 59:00: seconds frozen under tick_sec, up wraps to 00
    do_reset();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("setmin_5900", 32'(bus.value), 32'h5900);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    check("setmin_frozen", 32'(bus.value), 32'h5900);
    cyc(0, 0, 0, 1, 0);
    check("setmin_up_wrap", 32'(bus.value), 32'h0000);

    // Blink in SET_SEC
    do_reset();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 499; i++) cyc(0, 1, 0, 0, 0);
    check("blink_499", 32'(bus.digit_en), 32'hF);
    cyc(0, 1, 0, 0, 0);
    check("blink_500", 32'(bus.digit_en), 32'hC);
    cyc(0, 0, 0, 1, 0);
    check("blink_edit_clear", 32'(bus.digit_en), 32'hF);
    for (int i = 0; i < 500; i++) cyc(0, 1, 0, 0, 0);
    check("blink_again", 32'(bus.digit_en), 32'hC);

    // Priority: mode beats up; up+down no change; tick ignored leaving SET_MIN
    do_reset();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
    check("prio_0012", 32'(bus.value), 32'h0012);
    cyc(0, 0, 1, 1, 0);
    check("prio_mode_state", 32'(bus.state), 2);
    check("prio_mode_value", 32'(bus.value), 32'h0012);
    cyc(0, 0, 0, 1, 1);
    check("prio_updown", 32'(bus.value), 32'h0012);
    cyc(1, 0, 1, 0, 0);
    check("leave_tick_state", 32'(bus.state), 0);
    check("leave_tick_value", 32'(bus.value), 32'h0012);
    cyc(1, 0, 0, 0, 0);
    check("resume_count", 32'(bus.value), 32'h0013);

`ifdef WATCH_AUTO_EXIT_EN
    // Auto exit after idle seconds, then reset in the middle of SET_MIN
    do_reset();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < AUTO_EXIT_SEC; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("auto_exit_set_mode", 32'(bus.set_mode), 0);
    cyc(1, 0, 0, 0, 0);
    check("auto_exit_resume", 32'(bus.value), 32'h0001);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    do_reset();
    check("mid_reset_state", 32'(bus.state), 0);
    check("mid_reset_value", 32'(bus.value), 32'h0000);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      reset_p = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0);
    end
    reset_p = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
